// File: rtl/hub75_bcm_scanner.sv
// HUB75 scan engine with binary-coded modulation. The next bit-plane is shifted while the
// current one is on the panel, so shifting does not cost any display on-time.
module hub75_bcm_scanner #(
   parameter int COLS       = 64,
   parameter int ROW_ADDR_W = 5,
   parameter int BITS       = 4,
   parameter int BASE_DELAY = 64,
   parameter int BLANK_CYC  = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    en,
   input  logic [7:0]              bright,
   output logic                    fb_rd,
   output logic [$clog2(COLS)-1:0] fb_col,
   output logic [ROW_ADDR_W-1:0]   fb_row,
   input  logic [6*BITS-1:0]       fb_data,
   output logic [5:0]              hub_rgb,
   output logic                    hub_clk,
   output logic                    hub_lat,
   output logic                    hub_oe_n,
   output logic [ROW_ADDR_W-1:0]   hub_addr,
   output logic                    frame_start,
   output logic                    busy
);
   localparam int COL_W   = $clog2(COLS);
   localparam int SHIFT_N = 2*COLS + 2;
   localparam int CNT_W   = $clog2((SHIFT_N > BLANK_CYC) ? SHIFT_N : BLANK_CYC) + 1;
   localparam int PLANE_W = (BITS > 1) ? $clog2(BITS) : 1;
   localparam int WIN_W   = $clog2(BASE_DELAY) + BITS;
   localparam int PROD_W  = WIN_W + 9;

   localparam logic [CNT_W-1:0]   SHIFT_LAST = CNT_W'(SHIFT_N - 1);
   localparam logic [CNT_W-1:0]   SHIFT_COLS = CNT_W'(2*COLS);
   localparam logic [CNT_W-1:0]   BLANK_LAST = CNT_W'(BLANK_CYC - 1);
   localparam logic [PLANE_W-1:0] PLANE_LAST = PLANE_W'(BITS - 1);

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_SHIFT = 3'd1;
   localparam logic [2:0] ST_WAIT  = 3'd2;
   localparam logic [2:0] ST_BLANK = 3'd3;
   localparam logic [2:0] ST_LATCH = 3'd4;

   logic [2:0]            state_r, state_nx_s;
   logic [CNT_W-1:0]      cnt_r, cnt_nx_s;
   logic [ROW_ADDR_W-1:0] sh_row_r;
   logic [PLANE_W-1:0]    sh_plane_r;
   logic [WIN_W-1:0]      win_cnt_r, win_nx_s, on_cnt_r, on_nx_s;
   logic [WIN_W-1:0]      win_len_s, on_len_s;
   logic [PROD_W-1:0]     prod_s;
   logic [8:0]            bright_p1_s;
   logic                  win_done_s, rd_nx_s, clk_nx_s;
   logic [5:0]            rgb_s;

   for (genvar g = 0; g < 6; g++) begin : g_rgb
      logic [BITS-1:0] chan_s;
      assign chan_s   = fb_data[g*BITS +: BITS];
      assign rgb_s[g] = chan_s[sh_plane_r];
   end

   assign fb_row = sh_row_r;

   // Window length and on-time for the plane about to be latched; full-width product before the shift
   always_comb begin
      bright_p1_s = {1'b0, bright} + 9'd1;
      win_len_s   = WIN_W'(BASE_DELAY) << sh_plane_r;
      prod_s      = PROD_W'(win_len_s) * PROD_W'(bright_p1_s);
      on_len_s    = WIN_W'(prod_s >> 8);
      win_done_s  = (win_cnt_r <= WIN_W'(1));
   end

   // Next-state sequencing of the shift engine
   always_comb begin
      state_nx_s = state_r;
      cnt_nx_s   = cnt_r;
      case (state_r)
         ST_IDLE: begin
            cnt_nx_s = {CNT_W{1'b0}};
            if (en) state_nx_s = ST_SHIFT;
            else    state_nx_s = ST_IDLE;
         end
         ST_SHIFT: begin
            if (cnt_r == SHIFT_LAST) begin
               cnt_nx_s = {CNT_W{1'b0}};
               if (!win_done_s) state_nx_s = ST_WAIT;
               else if (en)     state_nx_s = ST_BLANK;
               else             state_nx_s = ST_IDLE;
            end else begin
               cnt_nx_s = cnt_r + CNT_W'(1);
            end
         end
         ST_WAIT: begin
            if (!win_done_s) state_nx_s = ST_WAIT;
            else if (en)     state_nx_s = ST_BLANK;
            else             state_nx_s = ST_IDLE;
         end
         ST_BLANK: begin
            if (cnt_r == BLANK_LAST) begin
               state_nx_s = ST_LATCH;
               cnt_nx_s   = {CNT_W{1'b0}};
            end else begin
               cnt_nx_s = cnt_r + CNT_W'(1);
            end
         end
         ST_LATCH: begin
            state_nx_s = ST_SHIFT;
            cnt_nx_s   = {CNT_W{1'b0}};
         end
         default: begin
            state_nx_s = ST_IDLE;
            cnt_nx_s   = {CNT_W{1'b0}};
         end
      endcase
   end

   // Window/on-time counters (loaded at latch) and shift-strobe look-ahead for the registered outputs
   always_comb begin
      if (state_r == ST_LATCH)              win_nx_s = win_len_s;
      else if (win_cnt_r != {WIN_W{1'b0}}) win_nx_s = win_cnt_r - WIN_W'(1);
      else                                  win_nx_s = win_cnt_r;
      if (state_r == ST_LATCH)              on_nx_s = on_len_s;
      else if (on_cnt_r != {WIN_W{1'b0}})  on_nx_s = on_cnt_r - WIN_W'(1);
      else                                  on_nx_s = on_cnt_r;
      rd_nx_s  = (state_nx_s == ST_SHIFT) && !cnt_nx_s[0] && (cnt_nx_s < SHIFT_COLS);
      clk_nx_s = (state_nx_s == ST_SHIFT) && cnt_nx_s[0] && (cnt_nx_s >= CNT_W'(3));
   end

   // Engine state, counters and the row/plane currently being shifted
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r    <= ST_IDLE;
         cnt_r      <= {CNT_W{1'b0}};
         win_cnt_r  <= {WIN_W{1'b0}};
         on_cnt_r   <= {WIN_W{1'b0}};
         sh_row_r   <= {ROW_ADDR_W{1'b0}};
         sh_plane_r <= {PLANE_W{1'b0}};
      end else begin
         state_r   <= state_nx_s;
         cnt_r     <= cnt_nx_s;
         win_cnt_r <= win_nx_s;
         on_cnt_r  <= on_nx_s;
         if (state_nx_s == ST_IDLE) begin
            sh_row_r   <= {ROW_ADDR_W{1'b0}};
            sh_plane_r <= {PLANE_W{1'b0}};
         end else if (state_r == ST_LATCH) begin
            if (sh_plane_r == PLANE_LAST) begin
               sh_plane_r <= {PLANE_W{1'b0}};
               sh_row_r   <= sh_row_r + ROW_ADDR_W'(1);
            end else begin
               sh_plane_r <= sh_plane_r + PLANE_W'(1);
            end
         end
      end
   end

   // Registered panel and frame-buffer outputs, driven from next-state so they align with the state
   always_ff @(posedge clk) begin
      if (!rst) begin
         fb_rd       <= 1'b0;
         fb_col      <= {COL_W{1'b0}};
         hub_rgb     <= 6'd0;
         hub_clk     <= 1'b0;
         hub_lat     <= 1'b0;
         hub_oe_n    <= 1'b1;
         hub_addr    <= {ROW_ADDR_W{1'b0}};
         frame_start <= 1'b0;
         busy        <= 1'b0;
      end else begin
         fb_rd       <= rd_nx_s;
         fb_col      <= rd_nx_s ? COL_W'(cnt_nx_s >> 1) : {COL_W{1'b0}};
         hub_clk     <= clk_nx_s;
         hub_lat     <= (state_nx_s == ST_LATCH);
         hub_oe_n    <= (on_nx_s == {WIN_W{1'b0}});
         frame_start <= (state_nx_s == ST_LATCH) && (sh_row_r == {ROW_ADDR_W{1'b0}}) &&
                        (sh_plane_r == {PLANE_W{1'b0}});
         busy        <= (state_nx_s != ST_IDLE);
         if (state_nx_s == ST_IDLE) begin
            hub_rgb  <= 6'd0;
            hub_addr <= {ROW_ADDR_W{1'b0}};
         end else begin
            if ((state_r == ST_SHIFT) && cnt_r[0] && (cnt_r < SHIFT_COLS)) hub_rgb <= rgb_s;
            if (state_nx_s == ST_LATCH) hub_addr <= sh_row_r;
         end
      end
   end
endmodule
